gpp_data_memory: RTL and testbench

GPP_DATA_MEMORY -- requirements
Module: gpp_data_memory

---
 rtl/gpp_data_memory.sv | 147 ++++++++++++++
 tb/tb_gpp_data_memory.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/gpp_data_memory.sv
// Dual-access data memory: GPP port with combinational read / synchronous write, plus a
// router request/response port served by an IDLE/ACCESS/RESP FSM. Macro GPP_MEM_RTR_WRITE_EN enables router writes.
module gpp_data_memory #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] address_rw,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  memory_write_enable,
    output logic [DATA_WIDTH-1:0] data_out,
    input  logic                  rtr_req_valid,
    output logic                  rtr_req_ready,
    input  logic                  rtr_req_write,
    input  logic [ADDR_WIDTH-1:0] rtr_req_addr,
    input  logic [DATA_WIDTH-1:0] rtr_req_wdata,
    output logic                  rtr_rsp_valid,
    input  logic                  rtr_rsp_ready,
    output logic [DATA_WIDTH-1:0] rtr_rsp_rdata,
    output logic                  rtr_rsp_err,
    output logic [CNT_WIDTH-1:0]  conflict_count
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

`ifdef GPP_MEM_RTR_WRITE_EN
    localparam logic RTR_WR_EN = 1'b1;
`else
    localparam logic RTR_WR_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    logic [DATA_WIDTH-1:0] mem_q [0:DEPTH-1];
    state_t                state_q;
    logic                  req_ready_q;
    logic                  req_write_q;
    logic [ADDR_WIDTH-1:0] req_addr_q;
    logic [DATA_WIDTH-1:0] req_wdata_q;
    logic                  rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;
    logic                  rsp_err_q;
    logic [CNT_WIDTH-1:0]  conflict_q;
    logic [CNT_WIDTH-1:0]  conflict_d;
    logic                  rtr_mem_we_s;

    // Router may touch the array only when the GPP is not writing this edge.
    assign rtr_mem_we_s = (state_q == ST_ACCESS) && req_write_q &&
                          !memory_write_enable && RTR_WR_EN;

    assign data_out       = mem_q[address_rw];
    assign rtr_req_ready  = req_ready_q;
    assign rtr_rsp_valid  = rsp_valid_q;
    assign rtr_rsp_rdata  = rsp_rdata_q;
    assign rtr_rsp_err    = rsp_err_q;
    assign conflict_count = conflict_q;

    // Saturating increment of the stall counter.
    always_comb begin
        conflict_d = conflict_q;
        if (conflict_q == {CNT_WIDTH{1'b1}}) begin
            conflict_d = conflict_q;
        end else begin
            conflict_d = conflict_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    // Storage array: GPP writes win; router writes land only from ACCESS.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {DATA_WIDTH{1'b0}};
            end
        end else if (memory_write_enable) begin
            mem_q[address_rw] <= data_in;
        end else if (rtr_mem_we_s) begin
            mem_q[req_addr_q] <= req_wdata_q;
        end
    end

    // Router FSM with registered handshake and response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b1;
            req_write_q <= 1'b0;
            req_addr_q  <= {ADDR_WIDTH{1'b0}};
            req_wdata_q <= {DATA_WIDTH{1'b0}};
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= {DATA_WIDTH{1'b0}};
            rsp_err_q   <= 1'b0;
            conflict_q  <= {CNT_WIDTH{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rtr_req_valid && req_ready_q) begin
                        req_write_q <= rtr_req_write;
                        req_addr_q  <= rtr_req_addr;
                        req_wdata_q <= rtr_req_wdata;
                        req_ready_q <= 1'b0;
                        state_q     <= ST_ACCESS;
                    end else begin
                        req_ready_q <= 1'b1;
                    end
                end
                ST_ACCESS: begin
                    if (memory_write_enable) begin
                        conflict_q <= conflict_d;
                    end else begin
                        state_q <= ST_RESP;
                        if (req_write_q) begin
                            rsp_rdata_q <= {DATA_WIDTH{1'b0}};
                            rsp_err_q   <= !RTR_WR_EN;
                        end else begin
                            rsp_rdata_q <= mem_q[req_addr_q];
                            rsp_err_q   <= 1'b0;
                        end
                    end
                end
                ST_RESP: begin
                    // Valid rises one cycle into RESP, then holds until consumed.
                    if (!rsp_valid_q) begin
                        rsp_valid_q <= 1'b1;
                    end else if (rtr_rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end else begin
                        rsp_valid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gpp_data_memory.sv
// Directed self-checking bench for gpp_data_memory; expectations follow GPP_MEM_RTR_WRITE_EN.
module tb_gpp_data_memory;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  address_rw;
    logic [15:0] data_in;
    logic        memory_write_enable;
    logic [15:0] data_out;
    logic        rtr_req_valid;
    logic        rtr_req_ready;
    logic        rtr_req_write;
    logic [4:0]  rtr_req_addr;
    logic [15:0] rtr_req_wdata;
    logic        rtr_rsp_valid;
    logic        rtr_rsp_ready;
    logic [15:0] rtr_rsp_rdata;
    logic        rtr_rsp_err;
    logic [7:0]  conflict_count;

    int tests  = 0;
    int failed = 0;

`ifdef GPP_MEM_RTR_WRITE_EN
    localparam logic [15:0] EXP_ADDR7 = 16'h1234;
    localparam logic        EXP_WERR  = 1'b0;
`else
    localparam logic [15:0] EXP_ADDR7 = 16'h0000;
    localparam logic        EXP_WERR  = 1'b1;
`endif

    gpp_data_memory dut (
        .clk                 (clk),
        .rst                 (rst),
        .address_rw          (address_rw),
        .data_in             (data_in),
        .memory_write_enable (memory_write_enable),
        .data_out            (data_out),
        .rtr_req_valid       (rtr_req_valid),
        .rtr_req_ready       (rtr_req_ready),
        .rtr_req_write       (rtr_req_write),
        .rtr_req_addr        (rtr_req_addr),
        .rtr_req_wdata       (rtr_req_wdata),
        .rtr_rsp_valid       (rtr_rsp_valid),
        .rtr_rsp_ready       (rtr_rsp_ready),
        .rtr_rsp_rdata       (rtr_rsp_rdata),
        .rtr_rsp_err         (rtr_rsp_err),
        .conflict_count      (conflict_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        address_rw = 5'd0; data_in = 16'h0; memory_write_enable = 1'b0;
        rtr_req_valid = 1'b0; rtr_req_write = 1'b0; rtr_req_addr = 5'd0;
        rtr_req_wdata = 16'h0; rtr_rsp_ready = 1'b1;
        #22 rst = 1'b0;
        #1;
        check("rst_ready", {31'd0, rtr_req_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, rtr_rsp_valid}, 32'd0);
        check("rst_rdata", {16'd0, rtr_rsp_rdata}, 32'd0);
        check("rst_err", {31'd0, rtr_rsp_err}, 32'd0);
        check("rst_count", {24'd0, conflict_count}, 32'd0);
        check("rst_data_out", {16'd0, data_out}, 32'd0);

        // GPP write addr 3
        address_rw = 5'd3; data_in = 16'hBEEF; memory_write_enable = 1'b1;
        #1 check("gpp_pre_write", {16'd0, data_out}, 32'd0);
        tick();
        memory_write_enable = 1'b0;
        check("gpp_write_vis", {16'd0, data_out}, 32'h0000BEEF);
        address_rw = 5'd4;
        #1 check("gpp_comb_other", {16'd0, data_out}, 32'd0);
        address_rw = 5'd3;
        #1 check("gpp_comb_back", {16'd0, data_out}, 32'h0000BEEF);

        // Router read addr 3, minimum latency
        rtr_req_valid = 1'b1; rtr_req_write = 1'b0; rtr_req_addr = 5'd3;
        tick();
        rtr_req_valid = 1'b0;
        check("rd_ready_low", {31'd0, rtr_req_ready}, 32'd0);
        check("rd_valid_n0", {31'd0, rtr_rsp_valid}, 32'd0);
        tick();
        check("rd_valid_n1", {31'd0, rtr_rsp_valid}, 32'd0);
        tick();
        check("rd_valid_n2", {31'd0, rtr_rsp_valid}, 32'd1);
        check("rd_rdata", {16'd0, rtr_rsp_rdata}, 32'h0000BEEF);
        check("rd_err", {31'd0, rtr_rsp_err}, 32'd0);
        tick();
        check("rd_idle_ready", {31'd0, rtr_req_ready}, 32'd1);
        check("rd_idle_valid", {31'd0, rtr_rsp_valid}, 32'd0);

        // Router write addr 7 stalled by 3 GPP writes
        rtr_req_valid = 1'b1; rtr_req_write = 1'b1; rtr_req_addr = 5'd7;
        rtr_req_wdata = 16'h1234;
        tick();
        rtr_req_valid = 1'b0;
        address_rw = 5'd10; data_in = 16'hAAAA; memory_write_enable = 1'b1;
        repeat (3) tick();
        memory_write_enable = 1'b0;
        check("wr_conflict3", {24'd0, conflict_count}, 32'd3);
        check("wr_stall_valid", {31'd0, rtr_rsp_valid}, 32'd0);
        tick();
        check("wr_valid_early", {31'd0, rtr_rsp_valid}, 32'd0);
        tick();
        check("wr_valid", {31'd0, rtr_rsp_valid}, 32'd1);
        check("wr_rdata", {16'd0, rtr_rsp_rdata}, 32'd0);
        check("wr_err", {31'd0, rtr_rsp_err}, {31'd0, EXP_WERR});
        tick();
        address_rw = 5'd7;
        #1 check("wr_addr7", {16'd0, data_out}, {16'd0, EXP_ADDR7});
        address_rw = 5'd10;
        #1 check("gpp_addr10", {16'd0, data_out}, 32'h0000AAAA);

        // Backpressure: rsp_ready low for 5 cycles
        rtr_rsp_ready = 1'b0;
        rtr_req_valid = 1'b1; rtr_req_write = 1'b0; rtr_req_addr = 5'd10;
        tick();
        rtr_req_valid = 1'b0;
        repeat (2) tick();
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", {31'd0, rtr_rsp_valid}, 32'd1);
            check("bp_rdata", {16'd0, rtr_rsp_rdata}, 32'h0000AAAA);
            check("bp_ready", {31'd0, rtr_req_ready}, 32'd0);
            tick();
        end
        rtr_rsp_ready = 1'b1;
        tick();
        check("bp_idle_ready", {31'd0, rtr_req_ready}, 32'd1);
        check("bp_idle_valid", {31'd0, rtr_rsp_valid}, 32'd0);

        // Reset during ACCESS
        rtr_req_valid = 1'b1; rtr_req_write = 1'b0; rtr_req_addr = 5'd3;
        tick();
        rtr_req_valid = 1'b0;
        rst = 1'b1;
        address_rw = 5'd3;
        #1 check("rst_async_mem", {16'd0, data_out}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("rst_no_rsp", {31'd0, rtr_rsp_valid}, 32'd0);
            check("rst_ready_hi", {31'd0, rtr_req_ready}, 32'd1);
            tick();
        end
        for (int a = 0; a < 32; a += 5) begin
            address_rw = a[4:0];
            #1 check("rst_word_zero", {16'd0, data_out}, 32'd0);
        end
        check("rst_count_zero", {24'd0, conflict_count}, 32'd0);

        // Saturation: 300 stall cycles; GPP writes the word being read
        rtr_req_valid = 1'b1; rtr_req_write = 1'b0; rtr_req_addr = 5'd5;
        tick();
        rtr_req_valid = 1'b0;
        address_rw = 5'd5; data_in = 16'h5A5A; memory_write_enable = 1'b1;
        repeat (10) tick();
        check("sat_count10", {24'd0, conflict_count}, 32'h0A);
        repeat (245) tick();
        check("sat_count255", {24'd0, conflict_count}, 32'hFF);
        repeat (45) tick();
        check("sat_count300", {24'd0, conflict_count}, 32'hFF);
        check("sat_ready", {31'd0, rtr_req_ready}, 32'd0);
        memory_write_enable = 1'b0;
        repeat (2) tick();
        check("sat_valid", {31'd0, rtr_rsp_valid}, 32'd1);
        check("sat_rdata", {16'd0, rtr_rsp_rdata}, 32'h00005A5A);
        check("sat_err", {31'd0, rtr_rsp_err}, 32'd0);
        tick();
        check("sat_idle", {31'd0, rtr_req_ready}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
